// File: rtl/seq_detect_ms.sv
// Serial pattern detector: matches a 1-bit stream against a PAT_W-bit pattern (fixed or run-time loaded).
// Latency: mealy_hit 0 cycles (same cycle as completing bit), moore_hit/hit_cnt 1 cycle after that edge.
// Backpressure: none; one bit accepted per en cycle, en=0 freezes all state.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   en, din         serial bit and its qualifier
//   pat_ld, pat_in  load a new pattern (MSB is the first expected bit); restarts the search
//   cnt_clr         synchronous clear of hit_cnt (a same-edge hit leaves it at 1)
//   mealy_hit       combinational: current din completes the pattern
//   moore_hit       FSM is in the full-match state
//   state           matched-prefix length 0..PAT_W
//   hit_cnt         saturating match counter
module seq_detect_ms #(
    parameter int         PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int         OVERLAP = 1,
    parameter int         CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         din,
    input  logic                         pat_ld,
    input  logic [PAT_W-1:0]             pat_in,
    input  logic                         cnt_clr,
    output logic                         mealy_hit,
    output logic                         moore_hit,
    output logic [$clog2(PAT_W+1)-1:0]   state,
    output logic [CNT_W-1:0]             hit_cnt
);

    localparam int SW = $clog2(PAT_W + 1);

    // States are the matched-prefix lengths S0..S_PAT_W, so the state type is
    // a plain count rather than an enumeration of fixed names.
    typedef logic [SW-1:0] state_t;

    localparam state_t           S_IDLE  = '0;
    localparam state_t           S_FULL  = SW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    state_t             valid_q, valid_d;
    state_t             k_next;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-1:0]   shifted;
    logic [PAT_W-1:0]   mask;
    logic [PAT_W-1:0]   pat_top;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    int                 lim;

    // Longest suffix of {history, din} that equals a prefix of the pattern.
    // Bit 0 of shifted is the newest bit; the top k pattern bits shifted down
    // line up with the k newest stream bits. Only bits actually accepted since
    // the last clear may take part, which keeps zero-filled history from
    // producing phantom prefixes and makes the result equal to a KMP walk.
    always_comb begin
        shifted = {hist_q[PAT_W-2:0], din};
        lim     = int'(valid_q) + 1;
        k_next  = S_IDLE;
        mask    = '0;
        pat_top = '0;
        for (int k = 1; k <= PAT_W; k++) begin
            mask    = PAT_W'((32'd1 << k) - 32'd1);
            pat_top = pat_q >> (PAT_W - k);
            if ((k <= lim) && (((shifted ^ pat_top) & mask) == '0)) begin
                k_next = SW'(k);
            end
        end
    end

    assign mealy_hit = en & ~pat_ld & ~reset & (k_next == S_FULL);
    assign moore_hit = (state_q == S_FULL);
    assign state     = state_q;
    assign hit_cnt   = cnt_q;

    // Next-state, history, pattern and counter updates.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;

        if (pat_ld) begin
            // New pattern: restart the search from scratch, din is discarded.
            pat_d   = pat_in;
            state_d = S_IDLE;
            hist_d  = '0;
            valid_d = '0;
        end else if (en) begin
            if ((k_next == S_FULL) && (OVERLAP == 0)) begin
                // Non-overlapping: nothing of this match may seed the next one.
                state_d = S_FULL;
                hist_d  = '0;
                valid_d = '0;
            end else begin
                state_d = k_next;
                hist_d  = shifted;
                valid_d = (valid_q == S_FULL) ? valid_q : valid_q + 1'b1;
            end
        end

        if (cnt_clr) begin
            cnt_d = mealy_hit ? CNT_W'(1) : '0;
        end else if (mealy_hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            hist_q  <= '0;
            pat_q   <= PATTERN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/seq_detect_ms.md
# seq_detect_ms

Parametrised serial pattern detector built as a multi-segment FSM. It is the generalised successor of the team's two-input Moore/Mealy example FSM. A one-bit input stream is compared against a PAT_W-bit pattern, which is either fixed by parameter or reloaded at run time. The block produces both a Mealy hit, flagged in the same cycle as the completing bit, and a Moore hit, flagged in the state after the match. It also supports overlap and non-overlap matching and keeps a saturating hit counter. It sits behind serial front-ends as a reusable framing and marker detector.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..16
- PATTERN, 4'b1011, reset/default pattern; MSB is the first bit expected
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match
- CNT_W, 8, hit counter width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  din is valid this cycle
- din  input  1  serial data bit
- pat_ld  input  1  load pat_in as the new pattern
- pat_in  input  PAT_W  new pattern, MSB first
- cnt_clr  input  1  synchronous clear of hit_cnt
- mealy_hit  output  1  combinational; the current din completes the pattern
- moore_hit  output  1  registered; the FSM is in the full-match state
- state  output  $clog2(PAT_W+1)  current matched-prefix length, 0..PAT_W
- hit_cnt  output  CNT_W  number of matches, saturating

## Operation
- States S0..S_PAT_W: S_k means the last k accepted bits equal the top k bits of the active pattern. S_PAT_W is the full-match (Moore) state.
- Next-state on en=1, computed combinationally:
  - k_next is the largest k ≤ PAT_W such that the low k bits of {history, din} equal pattern[PAT_W-1 -: k].
  - The search is restricted to k ≤ (valid bits + 1).
  - The block keeps a PAT_W-bit history shift register and a valid count. A KMP table is not required, but the result must be identical to one.
- OVERLAP=0: on the edge that completes a match, history and valid are cleared and the FSM enters S_PAT_W. The next accepted bit is evaluated against empty history.
- OVERLAP=1: history is kept, so suffix-prefix reuse applies from S_PAT_W.
- en=0:
  - state, history and the counter hold.
  - mealy_hit is 0.
  - moore_hit holds its value.
- mealy_hit = en & ~pat_ld & (k_next == PAT_W). It is purely combinational from state, history, din and en.
- moore_hit = (state == PAT_W).
- hit_cnt increments on each edge where mealy_hit=1 and saturates at 2^CNT_W-1.
  - If cnt_clr and a hit occur on the same edge, the result is 1.
  - If cnt_clr occurs alone, the result is 0.
- pat_ld=1, on the clock edge:
  - The pattern register loads pat_in; state goes to S0; history and valid are cleared.
  - din is ignored that cycle and mealy_hit is forced to 0.
  - hit_cnt is unaffected, and cnt_clr still applies on the same edge.
- Reset (asynchronous, any time, including mid-sequence) sets:
  - state=S0, history=0, valid=0;
  - pattern register = PATTERN;
  - hit_cnt=0, moore_hit=0.
  - mealy_hit reads 0 while reset is high.

## Timing
- Mealy latency is 0 cycles: mealy_hit is high in the cycle where the final pattern bit is on din with en=1.
- Moore latency is 1 cycle: moore_hit rises after the edge that samples the final bit. It stays high for 1 cycle per match while en stays high.
  - It stays high for consecutive cycles only when back-to-back overlapping matches occur (e.g. 1111).
  - It holds while en=0.
- hit_cnt updates on the same edge as moore_hit rises.
- The new pattern applies from the first en cycle after the pat_ld edge.
- One bit is accepted per clock; there is no back-pressure.

## Test plan
- Reset: assert reset mid-clock without a clock edge → state=0, moore_hit=0, hit_cnt=0 immediately. After release, mealy_hit=0 with din=1, en=1.
- Overlap, PATTERN=1011: stream 1,0,1,1,0,1,1 with en=1 → mealy_hit on bits 4 and 7, moore_hit high for the cycle after each, hit_cnt=2.
- Non-overlap (OVERLAP=0): same stream → a single hit on bit 4, hit_cnt=1, state=1 after bit 7.
- en gaps: same overlap stream with en=0 for 3 cycles between every bit → same hits; mealy_hit=0 in gap cycles; moore_hit held high through the gap that follows each match.
- Run-time load: after bits 1,0,1, pulse pat_ld with pat_in=1111, then five 1s → state resets to 0 on load. mealy_hit is high on the 4th and 5th bits, moore_hit is high for 2 consecutive cycles, and hit_cnt increases by 2.
- Saturation/clear with CNT_W=2: 5 matches → hit_cnt=3. Then cnt_clr together with a completing bit → hit_cnt=1. Then cnt_clr alone → 0. Finally, assert reset after 1,0,1, then send 1 → no hit; a full 1,0,1,1 is required.
